// File: rtl/sik_pkg.sv
// Shared op and error codes for the per-thread stack file.
package sik_pkg;

  typedef enum logic [2:0] {
    OP_READ  = 3'd0,
    OP_PUSH  = 3'd1,
    OP_POP   = 3'd2,
    OP_DUP   = 3'd3,
    OP_GET   = 3'd4,
    OP_PUT   = 3'd5,
    OP_REPL2 = 3'd6,
    OP_RSVD  = 3'd7
  } sik_op_e;

  typedef enum logic [1:0] {
    ERR_OK  = 2'd0,
    ERR_OVF = 2'd1,
    ERR_UNF = 2'd2,
    ERR_ILL = 2'd3
  } sik_err_e;

endpackage

// File: rtl/mt_stack_bank.sv
// Stack storage for all threads: NTHREADS*DEPTH words, two async read ports,
// one synchronous write port. Contents are deliberately not reset.
module mt_stack_bank #(
  parameter int NTHREADS = 2,
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 256,
  parameter int AW       = 9
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr0,
  output logic [WIDTH-1:0] rdata0,
  input  logic [AW-1:0]    raddr1,
  output logic [WIDTH-1:0] rdata1
);

  logic [WIDTH-1:0] mem [NTHREADS*DEPTH];

  // Single write port, committed on the accepting edge.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata0 = mem[raddr0];
  assign rdata1 = mem[raddr1];

endmodule

// File: rtl/mt_stack_file.sv
// Multi-thread stack file: one private stack per hardware thread, one
// request per cycle, single registered response stage.
module mt_stack_file
  import sik_pkg::*;
#(
  parameter int NTHREADS = 2,
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 256,
  localparam int SPW     = $clog2(DEPTH),
  localparam int TW      = (NTHREADS > 1) ? $clog2(NTHREADS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [TW-1:0]       req_thread,
  input  logic [2:0]          req_op,
  input  logic [WIDTH-1:0]    req_data,
  input  logic [SPW-1:0]      req_off,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [TW-1:0]       rsp_thread,
  output logic [WIDTH-1:0]    rsp_top,
  output logic [WIDTH-1:0]    rsp_next,
  output logic [1:0]          rsp_err,
  output logic [SPW:0]        rsp_count,
  output logic [NTHREADS-1:0] err_flags,
  input  logic [NTHREADS-1:0] err_clr
);

  localparam int CW = SPW + 1;
  localparam int AW = TW + SPW;

  // Per-thread count is kept instead of a bare sp so that full (sp all-ones)
  // and empty stay distinguishable; sp is derived as count-1. The top word is
  // mirrored in a register so the two bank read ports can serve next and the
  // GET/PUT offset entry in the same cycle.
  logic [CW-1:0]    cnt_q [NTHREADS];
  logic [WIDTH-1:0] top_q [NTHREADS];

  sik_op_e          op;
  logic             thr_ok, accept;
  logic [TW-1:0]    tsel;
  logic [CW-1:0]    cur_cnt, off_ext;
  logic [WIDTH-1:0] cur_top, rd0, rd1;
  logic [SPW-1:0]   sp;

  sik_err_e         err_c;
  logic [CW-1:0]    new_cnt;
  logic [WIDTH-1:0] new_top, wdata_c;
  logic [SPW-1:0]   wptr_c;
  logic             we_c;
  logic [NTHREADS-1:0] set_mask;

  assign op        = sik_op_e'(req_op);
  assign thr_ok    = (32'(req_thread) < NTHREADS);
  assign tsel      = thr_ok ? req_thread : '0;
  assign cur_cnt   = cnt_q[tsel];
  assign cur_top   = top_q[tsel];
  assign sp        = cur_cnt[SPW-1:0] - SPW'(1);
  assign off_ext   = {1'b0, req_off};
  assign req_ready = !rsp_valid || rsp_ready;
  assign accept    = req_valid && req_ready;

  mt_stack_bank #(
    .NTHREADS(NTHREADS),
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .AW      (AW)
  ) u_bank (
    .clk   (clk),
    .we    (accept && we_c),
    .waddr ({tsel, wptr_c}),
    .wdata (wdata_c),
    .raddr0({tsel, sp - SPW'(1)}),
    .rdata0(rd0),
    .raddr1({tsel, sp - req_off}),
    .rdata1(rd1)
  );

  // Op decode: checks in order illegal, underflow/range, overflow; state
  // changes only when every check passes.
  always_comb begin
    err_c   = ERR_OK;
    new_cnt = cur_cnt;
    new_top = cur_top;
    we_c    = 1'b0;
    wptr_c  = sp + SPW'(1);
    wdata_c = req_data;
    if (!thr_ok || op == OP_RSVD) begin
      err_c = ERR_ILL;
    end else begin
      case (op)
        OP_PUSH: begin
          if (cur_cnt == CW'(DEPTH)) err_c = ERR_OVF;
          else begin
            new_cnt = cur_cnt + CW'(1);
            new_top = req_data;
            we_c    = 1'b1;
          end
        end
        OP_POP: begin
          if (cur_cnt == '0) err_c = ERR_UNF;
          else begin
            new_cnt = cur_cnt - CW'(1);
            new_top = rd0;
          end
        end
        OP_DUP: begin
          if (cur_cnt == '0) err_c = ERR_UNF;
          else if (cur_cnt == CW'(DEPTH)) err_c = ERR_OVF;
          else begin
            new_cnt = cur_cnt + CW'(1);
            we_c    = 1'b1;
            wdata_c = cur_top;
          end
        end
        OP_GET: begin
          if (off_ext >= cur_cnt) err_c = ERR_UNF;
          else if (cur_cnt == CW'(DEPTH)) err_c = ERR_OVF;
          else begin
            new_cnt = cur_cnt + CW'(1);
            new_top = rd1;
            we_c    = 1'b1;
            wdata_c = rd1;
          end
        end
        OP_PUT: begin
          if (req_off == '0 || off_ext >= cur_cnt) err_c = ERR_UNF;
          else begin
            new_cnt = cur_cnt - CW'(1);
            // With offset 1 the slot just written becomes the new top.
            new_top = (req_off == SPW'(1)) ? cur_top : rd0;
            we_c    = 1'b1;
            wptr_c  = sp - req_off;
            wdata_c = cur_top;
          end
        end
        OP_REPL2: begin
          if (cur_cnt < CW'(2)) err_c = ERR_UNF;
          else begin
            new_cnt = cur_cnt - CW'(1);
            new_top = req_data;
            we_c    = 1'b1;
            wptr_c  = sp - SPW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Sticky error set mask for the addressed (legal) thread.
  always_comb begin
    set_mask = '0;
    for (int unsigned i = 0; i < NTHREADS; i++)
      set_mask[i] = accept && thr_ok && (err_c != ERR_OK) && (32'(tsel) == i);
  end

  // Per-thread counts and sticky errors; set wins over clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NTHREADS; i++) cnt_q[i] <= '0;
      err_flags <= '0;
    end else begin
      err_flags <= (err_flags & ~err_clr) | set_mask;
      if (accept && thr_ok) cnt_q[tsel] <= new_cnt;
    end
  end

  // Top-of-stack mirror, like storage not cleared by reset.
  always_ff @(posedge clk) begin
    if (accept && thr_ok) top_q[tsel] <= new_top;
  end

  // Response stage: load on accept, drop when taken, hold otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid  <= 1'b0;
      rsp_thread <= '0;
      rsp_top    <= '0;
      rsp_next   <= '0;
      rsp_err    <= '0;
      rsp_count  <= '0;
    end else if (accept) begin
      rsp_valid  <= 1'b1;
      rsp_thread <= req_thread;
      rsp_top    <= (thr_ok && cur_cnt != '0) ? cur_top : '0;
      rsp_next   <= (thr_ok && cur_cnt > CW'(1)) ? rd0 : '0;
      rsp_err    <= err_c;
      rsp_count  <= thr_ok ? new_cnt : '0;
    end else if (rsp_ready) begin
      rsp_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mt_stack_file.sv
// Bench for mt_stack_file: stack-level reference model, per-cycle compare,
// directed scenarios with literal expectations, then random traffic.
module tb_mt_stack_file;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [0:0]  req_thread = '0;
  logic [2:0]  req_op = '0;
  logic [15:0] req_data = '0;
  logic [1:0]  req_off = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [0:0]  rsp_thread;
  logic [15:0] rsp_top, rsp_next;
  logic [1:0]  rsp_err;
  logic [2:0]  rsp_count;
  logic [1:0]  err_flags;
  logic [1:0]  err_clr = '0;

  int nchk = 0;
  int nerr = 0;

  // Reference model: st[t][0] is the bottom, st[t][n[t]-1] the top.
  logic [15:0] st [2][D];
  int          n [2];
  bit          ev = 0;
  int          et = 0, eerr = 0, ecnt = 0;
  logic [15:0] etop = '0, enext = '0;
  logic [1:0]  ef = '0;
  bit          model_on = 0;

  always #5 clk = ~clk;

  mt_stack_file #(.NTHREADS(2), .WIDTH(16), .DEPTH(D)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_thread(req_thread),
    .req_op    (req_op),
    .req_data  (req_data),
    .req_off   (req_off),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_thread(rsp_thread),
    .rsp_top   (rsp_top),
    .rsp_next  (rsp_next),
    .rsp_err   (rsp_err),
    .rsp_count (rsp_count),
    .err_flags (err_flags),
    .err_clr   (err_clr)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit rst, input bit v, input int t, input int op,
                            input logic [15:0] d, input int off, input bit rr,
                            input logic [1:0] clr);
    int c, err;
    logic [1:0] setm;
    if (rst) begin
      n[0] = 0; n[1] = 0; ef = '0; ev = 0; et = 0;
      etop = '0; enext = '0; eerr = 0; ecnt = 0; model_on = 1;
      return;
    end
    setm = '0;
    if (v && (!ev || rr)) begin
      c = n[t];
      err = 0;
      if (op == 7) err = 3;
      else begin
        case (op)
          1: if (c == D) err = 1;
          2: if (c == 0) err = 2;
          3: if (c == 0) err = 2; else if (c == D) err = 1;
          4: if (off >= c) err = 2; else if (c == D) err = 1;
          5: if (off == 0 || off >= c) err = 2;
          6: if (c < 2) err = 2;
          default: ;
        endcase
      end
      ev = 1;
      et = t;
      etop  = (c > 0) ? st[t][c-1] : 16'h0;
      enext = (c > 1) ? st[t][c-2] : 16'h0;
      if (err == 0) begin
        case (op)
          1: begin st[t][c] = d; n[t] = c + 1; end
          2: n[t] = c - 1;
          3: begin st[t][c] = st[t][c-1]; n[t] = c + 1; end
          4: begin st[t][c] = st[t][c-1-off]; n[t] = c + 1; end
          5: begin st[t][c-1-off] = st[t][c-1]; n[t] = c - 1; end
          6: begin st[t][c-2] = d; n[t] = c - 1; end
          default: ;
        endcase
      end
      eerr = err;
      ecnt = n[t];
      if (err != 0) setm[t] = 1'b1;
    end else if (rr) begin
      ev = 0;
    end
    ef = (ef & ~clr) | setm;
  endtask

  // Compare process: every cycle, just after the edge.
  always @(posedge clk) begin
    #1;
    if (model_on) begin
      chk("rsp_valid", 32'(rsp_valid), 32'(ev));
      chk("err_flags", 32'(err_flags), 32'(ef));
      if (ev) begin
        chk("rsp_thread", 32'(rsp_thread), 32'(et));
        chk("rsp_top",    32'(rsp_top),    32'(etop));
        chk("rsp_next",   32'(rsp_next),   32'(enext));
        chk("rsp_err",    32'(rsp_err),    32'(eerr));
        chk("rsp_count",  32'(rsp_count),  32'(ecnt));
      end
    end
  end

  task automatic cyc(input bit rst, input bit v, input int t, input int op,
                     input logic [15:0] d, input int off, input bit rr,
                     input logic [1:0] clr, output bit acc);
    @(negedge clk);
    reset = rst; req_valid = v; req_thread = 1'(t); req_op = 3'(op);
    req_data = d; req_off = 2'(off); rsp_ready = rr; err_clr = clr;
    #1;
    if (model_on && !rst) chk("req_ready", 32'(req_ready), 32'(!ev || rr));
    acc = !rst && v && (!ev || rr);
    @(posedge clk);
    model_step(rst, v, t, op, d, off, rr, clr);
  endtask

  task automatic op1(input int t, input int op, input logic [15:0] d, input int off);
    bit a;
    cyc(0, 1, t, op, d, off, 1, 2'b00, a);
  endtask

  task automatic rst_cyc();
    bit a;
    cyc(1, 0, 0, 0, 16'h0, 0, 1, 2'b00, a);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit a;
    int k;
    int budget;

    rst_cyc();
    rst_cyc();
    #1;
    chk("reset_valid", 32'(rsp_valid), 32'h0);
    chk("reset_flags", 32'(err_flags), 32'h0);
    chk("reset_count", 32'(rsp_count), 32'h0);
    chk("reset_top",   32'(rsp_top),   32'h0);

    // PUSH, PUSH, READ on thread 0.
    op1(0, 1, 16'h1111, 0);
    op1(0, 1, 16'h2222, 0);
    op1(0, 0, 16'h0, 0);
    #1;
    chk("s40_top",   32'(rsp_top),   32'h2222);
    chk("s40_next",  32'(rsp_next),  32'h1111);
    chk("s40_count", 32'(rsp_count), 32'd2);
    chk("s40_err",   32'(rsp_err),   32'd0);

    // Five pushes to thread 1: the fifth overflows.
    for (int i = 0; i < 5; i++) op1(1, 1, 16'(16'h0500 + i), 0);
    #1;
    chk("s41_err",   32'(rsp_err),   32'd1);
    chk("s41_count", 32'(rsp_count), 32'd4);
    chk("s41_flags", 32'(err_flags), 32'b10);

    // POP on empty thread 0, then clear racing a failing POP.
    rst_cyc();
    op1(0, 2, 16'h0, 0);
    #1;
    chk("s42_err",   32'(rsp_err),   32'd2);
    chk("s42_flag",  32'(err_flags), 32'b01);
    cyc(0, 1, 0, 2, 16'h0, 0, 1, 2'b01, a);
    #1;
    chk("s42_setwins", 32'(err_flags), 32'b01);
    cyc(0, 1, 0, 0, 16'h0, 0, 1, 2'b01, a);
    #1;
    chk("s42_cleared", 32'(err_flags), 32'b00);

    // [A,B,C]: GET off 2 then PUT off 3.
    rst_cyc();
    op1(0, 1, 16'h000A, 0);
    op1(0, 1, 16'h000B, 0);
    op1(0, 1, 16'h000C, 0);
    op1(0, 4, 16'h0, 2);
    #1;
    chk("s43_get_count", 32'(rsp_count), 32'd4);
    op1(0, 0, 16'h0, 0);
    #1;
    chk("s43_get_top", 32'(rsp_top), 32'h000A);
    op1(0, 5, 16'h0, 3);
    #1;
    chk("s43_put_count", 32'(rsp_count), 32'd3);
    op1(0, 0, 16'h0, 0);
    #1;
    chk("s43_put_top",  32'(rsp_top),  32'h000C);
    chk("s43_put_next", 32'(rsp_next), 32'h000B);
    op1(0, 2, 16'h0, 0);
    op1(0, 2, 16'h0, 0);
    op1(0, 0, 16'h0, 0);
    #1;
    chk("s43_slot0", 32'(rsp_top), 32'h000A);
    chk("s43_cnt1",  32'(rsp_count), 32'd1);

    // Alternating pushes with the consumer stalled for three cycles.
    rst_cyc();
    k = 0;
    for (int i = 0; i < 6; i++) begin
      budget = 0;
      do begin
        cyc(0, 1, i % 2, 1, 16'(16'h0100 + i), 0, !(k >= 2 && k <= 4), 2'b00, a);
        k++;
        budget++;
      end while (!a && budget < 20);
      if (!a) chk("s44_accept_timeout", 32'h0, 32'h1);
    end
    op1(0, 0, 16'h0, 0);
    #1;
    chk("s44_t0_count", 32'(rsp_count), 32'd3);
    chk("s44_t0_top",   32'(rsp_top),   32'h0104);
    chk("s44_t0_next",  32'(rsp_next),  32'h0102);
    op1(1, 0, 16'h0, 0);
    #1;
    chk("s44_t1_count", 32'(rsp_count), 32'd3);
    chk("s44_t1_top",   32'(rsp_top),   32'h0105);

    // Reset with a response pending.
    cyc(0, 1, 0, 1, 16'h7777, 0, 0, 2'b00, a);
    cyc(0, 0, 0, 0, 16'h0, 0, 0, 2'b00, a);
    rst_cyc();
    #1;
    chk("s45_valid", 32'(rsp_valid), 32'h0);
    op1(0, 0, 16'h0, 0);
    #1;
    chk("s45_t0_count", 32'(rsp_count), 32'd0);
    op1(1, 0, 16'h0, 0);
    #1;
    chk("s45_t1_count", 32'(rsp_count), 32'd0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      int op;
      op = $urandom_range(0, 7);
      if ($urandom_range(0, 3) == 0) op = 1;
      cyc(($urandom_range(0, 149) == 0), ($urandom_range(0, 3) != 0),
          $urandom_range(0, 1), op, 16'($urandom), $urandom_range(0, 3),
          ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'b00, a);
    end
    cyc(0, 0, 0, 0, 16'h0, 0, 1, 2'b00, a);
    cyc(0, 0, 0, 0, 16'h0, 0, 1, 2'b00, a);
    #2;

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/mt_stack_file.md
MT_STACK_FILE -- requirements
Module: mt_stack_file

Interface
REQ-001 The block SHALL have parameter NTHREADS, default 2, meaning the number of hardware threads, each with a private stack.
REQ-002 The block SHALL have parameter WIDTH, default 16, meaning the data word width.
REQ-003 The block SHALL have parameter DEPTH, default 256, meaning entries per thread stack (power of two, >=4); SPW = log2(DEPTH), TW = max(1, log2(NTHREADS)).
REQ-004 clk  input  1  sole clock; all state updates on posedge clk.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  1  request present.
REQ-007 req_ready  output  1  request accepted this cycle when req_valid && req_ready.
REQ-008 req_thread  input  TW  target thread; values >= NTHREADS are illegal.
REQ-009 req_op  input  3  0 READ, 1 PUSH, 2 POP, 3 DUP, 4 GET, 5 PUT, 6 REPL2, 7 reserved.
REQ-010 req_data  input  WIDTH  value for PUSH and REPL2.
REQ-011 req_off  input  SPW  depth offset below top for GET and PUT.
REQ-012 rsp_valid  output  1  response held until taken.
REQ-013 rsp_ready  input  1  consumer takes the response.
REQ-014 rsp_thread  output  TW  thread of the response.
REQ-015 rsp_top / rsp_next  output  WIDTH each  top and second entries of that stack before the op; 0 if absent.
REQ-016 rsp_err  output  2  0 OK, 1 overflow, 2 underflow or offset out of range, 3 illegal op or thread.
REQ-017 rsp_count  output  SPW+1  entries in that stack after the op.
REQ-018 err_flags  output  NTHREADS  sticky per-thread error bits.
REQ-019 err_clr  input  NTHREADS  per-thread clear pulse for err_flags.

Function
REQ-020 Each thread SHALL keep sp of SPW bits; all-ones means empty; count = sp+1 with empty = 0.
REQ-021 req_ready SHALL equal !rsp_valid || rsp_ready; a single registered response stage with no skid buffer.
REQ-022 An accepted op SHALL update stack state on the accepting edge and present its response the next cycle (latency 1).
REQ-023 READ: no state change.
REQ-024 PUSH: fails with err 1 when count == DEPTH; otherwise sp+1, then write req_data at new top.
REQ-025 POP: fails with err 2 when count == 0; otherwise sp-1.
REQ-026 DUP: fails with err 2 when count == 0, then with err 1 when full; otherwise push a copy of top.
REQ-027 GET: fails with err 2 when req_off >= count, then with err 1 when full; otherwise push a copy of entry sp-req_off.
REQ-028 PUT: fails with err 2 when req_off == 0 or req_off >= count; otherwise write top into entry sp-req_off, then pop.
REQ-029 REPL2: fails with err 2 when count < 2; otherwise pop two entries and push req_data (net sp-1).
REQ-030 Op 7 or req_thread >= NTHREADS SHALL give err 3.
REQ-031 Any failed op SHALL leave sp and storage unchanged and set err_flags of the thread (err 3 with bad thread: no flag).
REQ-032 Checks SHALL apply in the order illegal, underflow/range, overflow; the first failing check sets rsp_err.
REQ-033 Back-to-back ops to one thread SHALL see the previous op's result with no stall; threads SHALL be independent.
REQ-034 An err_clr bit and an error set on the same thread in the same cycle SHALL resolve with set winning.
REQ-035 While rsp_valid && !rsp_ready, outputs SHALL hold stable and no request SHALL be accepted.

Reset
REQ-036 Reset SHALL empty all stacks, clear err_flags, and force rsp_valid = 0, rsp_err = 0, rsp_top = 0, rsp_next = 0, rsp_count = 0, rsp_thread = 0.
REQ-037 Reset SHALL not clear storage contents, and SHALL drop a pending response.

Structure
REQ-038 Op codes and error codes SHALL be in shared package sik_pkg.
REQ-039 Storage SHALL be one sub-module mt_stack_bank: NTHREADS*DEPTH x WIDTH, two read ports and one write port.

Verification
REQ-040 Scenario: thread 0 PUSH 0x1111, PUSH 0x2222, READ -> READ response top 0x2222, next 0x1111, count 2, err 0.
REQ-041 Scenario: DEPTH=4, thread 1 gets five PUSHes -> fifth has err 1, count 4, err_flags[1] = 1, err_flags[0] = 0.
REQ-042 Scenario: POP on empty thread 0 -> err 2; then err_clr[0] and a failing POP in the same cycle -> flag stays 1.
REQ-043 Scenario: stack [A,B,C] (C top), GET off 2 -> top A, count 4; then PUT off 3 -> slot 0 = A, count 3.
REQ-044 Scenario: alternate threads 0/1 with PUSH every cycle and rsp_ready held low 3 cycles -> no lost or duplicated responses, per-thread counts correct.
REQ-045 Scenario: reset asserted with rsp_valid pending -> next cycle rsp_valid = 0, all counts 0.
